channel_frame_scheduler: RTL and testbench

//  Shares the single noisy bit channel between two serial requesters (e.g. two encoder lanes).

---
 rtl/channel_frame_scheduler_pkg.sv | 18 +
 rtl/channel_frame_scheduler_arbiter.sv | 21 ++
 rtl/channel_frame_scheduler.sv | 179 +++++++++++++++++
 tb/tb_channel_frame_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_frame_scheduler_pkg.sv
// Shared constants and helpers for the two-requester channel frame scheduler.
package channel_frame_scheduler_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam int unsigned OWNER_W  = 1;
    localparam logic [1:0]  GNT_NONE = 2'b00;

    function automatic logic [1:0] owner_onehot(input logic [OWNER_W-1:0] idx);
        logic [1:0] oh;
        oh      = 2'b00;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/channel_frame_scheduler_arbiter.sv
// Two-way round-robin pick between frame requesters, purely combinational.
module rr_arbiter2
    import channel_frame_scheduler_pkg::*;
(
    input  logic [1:0]         req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic               grant_valid,
    output logic [OWNER_W-1:0] winner
);

    // A tie goes to the requester that did not own the channel last.
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/channel_frame_scheduler.sv
// Grants whole frames of the shared bit channel to one of two requesters and
// routes data to and from the owner while counting injected channel errors.
module channel_frame_scheduler
    import channel_frame_scheduler_pkg::*;
#(
    parameter int FRAME_LEN  = 16,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [1:0]                     REQ,
    output logic [1:0]                     GNT,
    input  logic [1:0]                     SRC_DATA,
    input  logic [1:0]                     SRC_VALID,
    output logic                           CH_DATA_IN,
    output logic                           CH_DATA_IN_VALID,
    input  logic                           CH_DATA_OUT,
    input  logic                           CH_DATA_OUT_VALID,
    input  logic                           CH_ERROR_VALID,
    output logic [1:0]                     DST_DATA,
    output logic [1:0]                     DST_VALID,
    output logic [1:0]                     FRAME_DONE,
    output logic                           FRAME_ABORT,
    output logic [$clog2(FRAME_LEN+1)-1:0] FRAME_ERRORS,
    output logic [CNT_W-1:0]               ERR_TOTAL0,
    output logic [CNT_W-1:0]               ERR_TOTAL1
);

    localparam int FE_W     = $clog2(FRAME_LEN + 1);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [FE_W-1:0] BEAT_LAST     = FE_W'(FRAME_LEN - 1);
    localparam logic [1:0]      S_AFTER_FRAME = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic [1:0]         state_q,    state_d;
    logic [1:0]         gnt_q,      gnt_d;
    logic [OWNER_W-1:0] last_q,     last_d;
    logic [FE_W-1:0]    beat_q,     beat_d;
    logic [FE_W-1:0]    ferr_q,     ferr_d;
    logic [GAP_W-1:0]   gap_q,      gap_d;
    logic [1:0]         done_q,     done_d;
    logic               abort_q,    abort_d;
    logic [FE_W-1:0]    ferr_out_q, ferr_out_d;
    logic [CNT_W-1:0]   tot0_q,     tot0_d;
    logic [CNT_W-1:0]   tot1_q,     tot1_d;

    logic               arb_valid_s;
    logic [OWNER_W-1:0] arb_winner_s;
    logic               beat_s;
    logic               hit_s;
    logic [FE_W-1:0]    ferr_inc_s;

    rr_arbiter2 u_arb (
        .req         (REQ),
        .last_owner  (last_q),
        .grant_valid (arb_valid_s),
        .winner      (arb_winner_s)
    );

    // Owner mux into the channel and demux back out; zero latency from the registered grant.
    always_comb begin
        CH_DATA_IN       = |(gnt_q & SRC_DATA);
        CH_DATA_IN_VALID = |(gnt_q & SRC_VALID);
        DST_DATA         = gnt_q & {2{CH_DATA_OUT}};
        DST_VALID        = gnt_q & {2{CH_DATA_OUT_VALID}};
        beat_s           = |(gnt_q & SRC_VALID);
        hit_s            = beat_s & CH_ERROR_VALID;
        ferr_inc_s       = ferr_q + FE_W'(hit_s);
    end

    // Frame FSM: arbitration, beat/error counting, frame close and inter-frame gap.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        beat_d     = beat_q;
        ferr_d     = ferr_q;
        gap_d      = gap_q;
        done_d     = 2'b00;
        abort_d    = 1'b0;
        ferr_out_d = ferr_out_q;
        tot0_d     = tot0_q;
        tot1_d     = tot1_q;
        case (state_q)
            S_IDLE: begin
                if (arb_valid_s) begin
                    state_d = S_GRANT;
                    gnt_d   = owner_onehot(arb_winner_s);
                    last_d  = arb_winner_s;
                    beat_d  = '0;
                    ferr_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                beat_d = beat_q + FE_W'(beat_s);
                ferr_d = ferr_inc_s;
                if (hit_s) begin
                    if (last_q == 1'b1) begin
                        tot1_d = sat_inc(tot1_q);
                    end else begin
                        tot0_d = sat_inc(tot0_q);
                    end
                end else begin
                    tot0_d = tot0_q;
                end
                // A beat that lands while REQ drops still counts; abort only on a beat-free cycle.
                if ((beat_s && (beat_q == BEAT_LAST)) || (!REQ[last_q] && !beat_s)) begin
                    state_d    = S_AFTER_FRAME;
                    gnt_d      = GNT_NONE;
                    done_d     = owner_onehot(last_q);
                    abort_d    = !beat_s;
                    ferr_out_d = ferr_inc_s;
                    gap_d      = '0;
                end else begin
                    state_d = S_GRANT;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // State registers; last owner resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            gnt_q      <= GNT_NONE;
            last_q     <= 1'b1;
            beat_q     <= '0;
            ferr_q     <= '0;
            gap_q      <= '0;
            done_q     <= 2'b00;
            abort_q    <= 1'b0;
            ferr_out_q <= '0;
            tot0_q     <= '0;
            tot1_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            ferr_q     <= ferr_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            ferr_out_q <= ferr_out_d;
            tot0_q     <= tot0_d;
            tot1_q     <= tot1_d;
        end
    end

    assign GNT          = gnt_q;
    assign FRAME_DONE   = done_q;
    assign FRAME_ABORT  = abort_q;
    assign FRAME_ERRORS = ferr_out_q;
    assign ERR_TOTAL0   = tot0_q;
    assign ERR_TOTAL1   = tot1_q;

endmodule

// File: tb/tb_channel_frame_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a frame-level model.
module tb_channel_frame_scheduler;

    localparam int FRAME_LEN  = 16;
    localparam int GAP_CYCLES = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] REQ = 2'b00;
    logic [1:0] SRC_DATA = 2'b00;
    logic [1:0] SRC_VALID = 2'b00;
    logic       err_flag = 1'b0;

    logic [1:0]  GNT, DST_DATA, DST_VALID, FRAME_DONE;
    logic        CH_DATA_IN, CH_DATA_IN_VALID, FRAME_ABORT;
    logic [4:0]  FRAME_ERRORS;
    logic [15:0] ERR_TOTAL0, ERR_TOTAL1;
    logic        ch_out, ch_out_v, ch_err;

    logic [1:0]  b_GNT, b_DST_DATA, b_DST_VALID, b_FRAME_DONE;
    logic        b_CH_DATA_IN, b_CH_DATA_IN_VALID, b_FRAME_ABORT;
    logic [4:0]  b_FRAME_ERRORS;
    logic [3:0]  b_ERR_TOTAL0, b_ERR_TOTAL1;
    logic        b_ch_out, b_ch_out_v, b_ch_err;

    // Channel model: flips the bit whenever the error flag is set.
    assign ch_out     = CH_DATA_IN ^ err_flag;
    assign ch_out_v   = CH_DATA_IN_VALID;
    assign ch_err     = err_flag & CH_DATA_IN_VALID;
    assign b_ch_out   = b_CH_DATA_IN ^ err_flag;
    assign b_ch_out_v = b_CH_DATA_IN_VALID;
    assign b_ch_err   = err_flag & b_CH_DATA_IN_VALID;

    always #5 CLK = ~CLK;

    channel_frame_scheduler #(.FRAME_LEN(FRAME_LEN), .GAP_CYCLES(GAP_CYCLES), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT), .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID),
        .CH_DATA_IN(CH_DATA_IN), .CH_DATA_IN_VALID(CH_DATA_IN_VALID), .CH_DATA_OUT(ch_out),
        .CH_DATA_OUT_VALID(ch_out_v), .CH_ERROR_VALID(ch_err), .DST_DATA(DST_DATA),
        .DST_VALID(DST_VALID), .FRAME_DONE(FRAME_DONE), .FRAME_ABORT(FRAME_ABORT),
        .FRAME_ERRORS(FRAME_ERRORS), .ERR_TOTAL0(ERR_TOTAL0), .ERR_TOTAL1(ERR_TOTAL1)
    );

    channel_frame_scheduler #(.FRAME_LEN(FRAME_LEN), .GAP_CYCLES(GAP_CYCLES), .CNT_W(4)) dut_narrow (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(b_GNT), .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID),
        .CH_DATA_IN(b_CH_DATA_IN), .CH_DATA_IN_VALID(b_CH_DATA_IN_VALID), .CH_DATA_OUT(b_ch_out),
        .CH_DATA_OUT_VALID(b_ch_out_v), .CH_ERROR_VALID(b_ch_err), .DST_DATA(b_DST_DATA),
        .DST_VALID(b_DST_VALID), .FRAME_DONE(b_FRAME_DONE), .FRAME_ABORT(b_FRAME_ABORT),
        .FRAME_ERRORS(b_FRAME_ERRORS), .ERR_TOTAL0(b_ERR_TOTAL0), .ERR_TOTAL1(b_ERR_TOTAL1)
    );

    int checks = 0;
    int failures = 0;

    // Frame-level model: owner (-1 = none), progress in the frame, gap cycles left, lifetime totals.
    int m_owner, m_last, m_beats, m_ferr, m_wait, m_done, m_abort, m_ferr_out;
    int m_tot[2];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int oh(input int o);
        return (o < 0) ? 0 : (1 << o);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_beats = 0; m_ferr = 0; m_wait = 0;
        m_done = -1; m_abort = 0; m_ferr_out = 0; m_tot[0] = 0; m_tot[1] = 0;
    endtask

    task automatic model_step(input logic [1:0] req, input logic [1:0] val, input logic e);
        int beat;
        int hit;
        m_done  = -1;
        m_abort = 0;
        if (m_owner >= 0) begin
            beat = int'(val[m_owner]);
            hit  = beat & int'(e);
            m_beats += beat;
            m_ferr  += hit;
            m_tot[m_owner] += hit;
            if (m_beats == FRAME_LEN || (req[m_owner] == 1'b0 && beat == 0)) begin
                m_done     = m_owner;
                m_abort    = (m_beats == FRAME_LEN) ? 0 : 1;
                m_ferr_out = m_ferr;
                m_owner    = -1;
                m_wait     = GAP_CYCLES;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (req != 2'b00) begin
            m_owner = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
            m_last  = m_owner;
            m_beats = 0;
            m_ferr  = 0;
        end
    endtask

    task automatic check_regs();
        chk("gnt", int'(GNT), oh(m_owner));
        chk("frame_done", int'(FRAME_DONE), oh(m_done));
        if (m_done >= 0) chk("frame_abort", int'(FRAME_ABORT), m_abort);
        chk("frame_errors", int'(FRAME_ERRORS), m_ferr_out);
        chk("err_total0", int'(ERR_TOTAL0), sat(m_tot[0], 65535));
        chk("err_total1", int'(ERR_TOTAL1), sat(m_tot[1], 65535));
        chk("n_gnt", int'(b_GNT), oh(m_owner));
        chk("n_frame_done", int'(b_FRAME_DONE), oh(m_done));
        if (m_done >= 0) chk("n_frame_abort", int'(b_FRAME_ABORT), m_abort);
        chk("n_frame_errors", int'(b_FRAME_ERRORS), m_ferr_out);
        chk("n_err_total0", int'(b_ERR_TOTAL0), sat(m_tot[0], 15));
        chk("n_err_total1", int'(b_ERR_TOTAL1), sat(m_tot[1], 15));
    endtask

    task automatic check_comb(input logic [1:0] dat, input logic [1:0] val, input logic e);
        int ed;
        int ev;
        ed = 0;
        ev = 0;
        if (m_owner >= 0) begin
            ed = int'(dat[m_owner]);
            ev = int'(val[m_owner]);
        end
        chk("ch_data_in", int'(CH_DATA_IN), ed);
        chk("ch_data_in_valid", int'(CH_DATA_IN_VALID), ev);
        chk("dst_data", int'(DST_DATA), (ed ^ int'(e)) * oh(m_owner));
        chk("dst_valid", int'(DST_VALID), ev * oh(m_owner));
        chk("n_ch_data_in", int'(b_CH_DATA_IN), ed);
        chk("n_dst_data", int'(b_DST_DATA), (ed ^ int'(e)) * oh(m_owner));
        chk("n_dst_valid", int'(b_DST_VALID), ev * oh(m_owner));
    endtask

    // One clock: drive at the falling edge, check combinational paths, advance model, check registers.
    task automatic cycle(input logic [1:0] req, input logic [1:0] val, input logic [1:0] dat, input logic e);
        REQ = req; SRC_VALID = val; SRC_DATA = dat; err_flag = e;
        #1;
        check_comb(dat, val, e);
        model_step(req, val, e);
        @(negedge CLK);
        check_regs();
    endtask

    // Assert reset asynchronously at a falling edge, then release two cycles later.
    task automatic do_reset();
        RESET = 1'b0; REQ = 2'b00; SRC_VALID = 2'b00; SRC_DATA = 2'b00; err_flag = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt", int'(GNT), 0);
        chk("rst_frame_done", int'(FRAME_DONE), 0);
        @(negedge CLK);
        chk("rst_frame_abort", int'(FRAME_ABORT), 0);
        chk("rst_frame_errors", int'(FRAME_ERRORS), 0);
        chk("rst_totals", int'(ERR_TOTAL0) + int'(ERR_TOTAL1), 0);
        @(negedge CLK);
        RESET = 1'b1;
        check_regs();
    endtask

    initial begin
        int n;
        int nb;
        int ne;
        int ndone;
        int p;
        int probs[4];
        int seq[$];
        logic [1:0] prev;
        logic [1:0] rq;
        logic [1:0] vv;
        logic [1:0] tv;
        logic e;

        model_reset();
        @(negedge CLK);
        do_reset();

        // T1: single requester, clean channel
        cycle(2'b01, 2'b01, 2'($urandom), 1'b0);
        chk("t1_gnt_after_one", int'(GNT), 1);
        n = 0;
        while (FRAME_DONE == 2'b00 && n < 40) begin
            cycle(2'b01, 2'b01, 2'($urandom), 1'b0);
            n++;
        end
        chk("t1_beats_to_done", n, 16);
        chk("t1_frame_done", int'(FRAME_DONE), 1);
        chk("t1_frame_errors", int'(FRAME_ERRORS), 0);
        chk("t1_gnt_closed", int'(GNT), 0);
        cycle(2'b01, 2'b01, 2'($urandom), 1'b0);
        chk("t1_gap1", int'(GNT), 0);
        cycle(2'b01, 2'b01, 2'($urandom), 1'b0);
        chk("t1_gap2", int'(GNT), 0);

        // T2: both requesting constantly, grants alternate starting with 0
        do_reset();
        prev = 2'b00;
        for (int k = 0; k < 300 && seq.size() < 4; k++) begin
            cycle(2'b11, 2'b11, 2'($urandom), 1'b0);
            if (prev == 2'b00 && GNT != 2'b00) seq.push_back(int'(GNT));
            prev = GNT;
        end
        chk("t2_grant_count", seq.size(), 4);
        for (int k = 0; k < seq.size(); k++) chk("t2_grant_order", seq[k], (k % 2 == 0) ? 1 : 2);

        // T3: every beat corrupted, requester 1 alone
        do_reset();
        n = 0;
        cycle(2'b10, 2'b10, 2'($urandom), 1'b1);
        while (FRAME_DONE == 2'b00 && n < 40) begin
            cycle(2'b10, 2'b10, 2'($urandom), 1'b1);
            n++;
        end
        chk("t3_frame_done", int'(FRAME_DONE), 2);
        chk("t3_frame_errors", int'(FRAME_ERRORS), 16);
        chk("t3_err_total1", int'(ERR_TOTAL1), 16);
        chk("t3_err_total0", int'(ERR_TOTAL0), 0);

        // T4: toggling valid, REQ dropped after 5 beats
        nb = 0; ne = 0; n = 0;
        while (nb < 5 && n < 100) begin
            tv = (n % 2 == 0) ? 2'b01 : 2'b00;
            e = 1'($urandom);
            if (m_owner == 0 && tv[0]) begin
                nb++;
                ne += int'(e);
            end
            cycle(2'b01, tv, 2'($urandom), e);
            n++;
        end
        cycle(2'b00, 2'b00, 2'($urandom), 1'b0);
        chk("t4_frame_done", int'(FRAME_DONE), 1);
        chk("t4_frame_abort", int'(FRAME_ABORT), 1);
        chk("t4_frame_errors", int'(FRAME_ERRORS), ne);

        // T5: two corrupted frames saturate the 4-bit counter
        do_reset();
        ndone = 0; n = 0;
        while (ndone < 2 && n < 100) begin
            cycle(2'b01, 2'b01, 2'($urandom), 1'b1);
            if (FRAME_DONE != 2'b00) ndone++;
            n++;
        end
        chk("t5_narrow_total0", int'(b_ERR_TOTAL0), 15);
        chk("t5_wide_total0", int'(ERR_TOTAL0), 32);

        // T6: reset in the middle of a frame
        do_reset();
        nb = 0; n = 0;
        while (nb < 7 && n < 50) begin
            if (m_owner == 0) nb++;
            cycle(2'b01, 2'b01, 2'($urandom), 1'b0);
            n++;
        end
        do_reset();
        cycle(2'b11, 2'b11, 2'($urandom), 1'b0);
        chk("t6_first_after_reset", int'(GNT), 1);

        // Randomized traffic with a sweep of error rates
        probs[0] = 0; probs[1] = 100; probs[2] = 30; probs[3] = 5;
        rq = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            p = probs[k / 750];
            for (int i = 0; i < 2; i++) begin
                if (m_owner == i) begin
                    if ($urandom_range(0, 39) == 0) rq[i] = 1'b0;
                end else if (rq[i] == 1'b0) begin
                    rq[i] = ($urandom_range(0, 3) == 0);
                end
                vv[i] = ($urandom_range(0, 3) != 0);
            end
            e = ($urandom_range(0, 99) < p);
            cycle(rq, vv, 2'($urandom), e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
